// File: rtl/ecc_pmul_pkg.sv
// ecc_pmul_pkg
// Shared constants and the drain-state encoding for the P-256 point-multiply
// result capture buffer.
//   WORDS       : 32-bit words per coordinate
//   BYTES       : bytes in the full rx||ry stream
//   BITMAP_FULL : write bitmap value when every word has been written
package ecc_pmul_pkg;

    localparam int          WORDS       = 8;
    localparam int          BYTES       = 64;
    localparam logic [15:0] BITMAP_FULL = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } drain_state_e;

endpackage

// File: rtl/ecc_word_store.sv
// ecc_word_store
// Small register file holding one coordinate of the point-multiply result.
// Storage has no reset; contents are only meaningful once written.
// Ports:
//   crypto_clk         clock
//   wr_en/wr_addr/wr_data  single write port
//   rd_word/rd_byte    word and byte lane select (byte 0 = bits 7:0)
//   rd_data            selected byte, combinational
module ecc_word_store
    import ecc_pmul_pkg::*;
#(
    parameter int pDEPTH  = WORDS,
    parameter int pWORD_W = 32
)(
    input  logic               crypto_clk,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [pWORD_W-1:0] wr_data,
    input  logic [2:0]         rd_word,
    input  logic [1:0]         rd_byte,
    output logic [7:0]         rd_data
);

    logic [pWORD_W-1:0] mem [pDEPTH];

    always_ff @(posedge crypto_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_word][{rd_byte, 3'b000} +: 8];

endmodule

// File: rtl/ecc_pmul_result_drain.sv
// ecc_pmul_result_drain
// Captures the rx/ry result words written by the point-multiply core and
// drains them as a 64-byte MSB-first stream (rx word 7 byte 3 first, ry word
// 0 byte 0 last) over a valid/ready handshake.
// Optional feature macro: ECC_PMUL_LOCKSTEP_CMP_EN adds rx_b_din_i/ry_b_din_i
// from a lockstep core and flags any difference on mismatch_o.
// Ports:
//   crypto_clk, reset_i (sync, active high), start_i (clear and arm)
//   core_rdy_i          core idle/finished level; rising edge ends FILL
//   rx_*/ry_*           word write interfaces (addr 0 = least-significant word)
//   out_valid_o/out_ready_i/out_data_o/out_last_o  byte stream
//   drain_done_o        pulse after the last byte is accepted
//   err_incomplete_o, err_overrun_o, mismatch_o    sticky status
//
// state | meaning
// IDLE  | nothing armed; writes ignored
// FILL  | accepting result words, waiting for core_rdy_i to rise
// FULL  | result held, byte 0 offered, nothing accepted yet
// DRAIN | streaming bytes 1..63
module ecc_pmul_result_drain
    import ecc_pmul_pkg::*;
#(
    parameter int pWORDS  = WORDS,
    parameter int pWORD_W = 32
)(
    input  logic               crypto_clk,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               core_rdy_i,
    input  logic [2:0]         rx_addr_i,
    input  logic               rx_wren_i,
    input  logic [pWORD_W-1:0] rx_din_i,
    input  logic [2:0]         ry_addr_i,
    input  logic               ry_wren_i,
    input  logic [pWORD_W-1:0] ry_din_i,
`ifdef ECC_PMUL_LOCKSTEP_CMP_EN
    input  logic [pWORD_W-1:0] rx_b_din_i,
    input  logic [pWORD_W-1:0] ry_b_din_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [7:0]         out_data_o,
    output logic               out_last_o,
    output logic               drain_done_o,
    output logic               err_incomplete_o,
    output logic               err_overrun_o,
    output logic               mismatch_o
);

    drain_state_e state, state_nxt;

    logic [15:0] bitmap;
    logic [15:0] wr_bits;
    logic [15:0] bitmap_upd;
    logic [5:0]  byte_cnt;
    logic        rdy_q;
    logic        rdy_rise;
    logic        wr_accept;
    logic        any_wr;
    logic        hs;
    logic        last_byte;
    logic        wr_mismatch;
    logic        inc_q, ovr_q, mm_q, done_q;
    logic [7:0]  rx_byte, ry_byte;

    assign rdy_rise   = core_rdy_i & ~rdy_q;
    // The start cycle's writes land in the freshly cleared buffer.
    assign wr_accept  = start_i | (state == FILL);
    assign any_wr     = rx_wren_i | ry_wren_i;
    assign hs         = out_valid_o & out_ready_i;
    assign last_byte  = (byte_cnt == 6'(BYTES - 1));
    assign bitmap_upd = bitmap | wr_bits;

    // Bitmap bit index is {coord, addr}: rx in bits 7:0, ry in bits 15:8.
    always_comb begin
        wr_bits = '0;
        if (rx_wren_i) wr_bits[{1'b0, rx_addr_i}] = 1'b1;
        if (ry_wren_i) wr_bits[{1'b1, ry_addr_i}] = 1'b1;
    end

`ifdef ECC_PMUL_LOCKSTEP_CMP_EN
    assign wr_mismatch = (rx_wren_i && (rx_b_din_i != rx_din_i)) ||
                         (ry_wren_i && (ry_b_din_i != ry_din_i));
`else
    assign wr_mismatch = 1'b0;
`endif

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        out_valid_o = 1'b0;
        case (state)
            IDLE: ;
            FILL: begin
                if (rdy_rise) state_nxt = FULL;
            end
            FULL: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nxt = last_byte ? IDLE : DRAIN;
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i && last_byte) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Restart wins over everything, including a byte being accepted.
        if (start_i) state_nxt = FILL;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            bitmap   <= '0;
            byte_cnt <= '0;
            rdy_q    <= 1'b0;
            inc_q    <= 1'b0;
            ovr_q    <= 1'b0;
            mm_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rdy_q  <= core_rdy_i;
            done_q <= 1'b0;
            if (start_i) begin
                bitmap   <= wr_bits;
                byte_cnt <= '0;
                inc_q    <= 1'b0;
                ovr_q    <= 1'b0;
                mm_q     <= wr_mismatch;
            end else begin
                if (state == FILL) begin
                    bitmap <= bitmap_upd;
                    if (wr_mismatch) mm_q <= 1'b1;
                    if (rdy_rise && (bitmap_upd != BITMAP_FULL)) inc_q <= 1'b1;
                end
                if (out_valid_o && any_wr) ovr_q <= 1'b1;
                if (hs) begin
                    byte_cnt <= byte_cnt + 6'd1;
                    if (last_byte) done_q <= 1'b1;
                end
            end
        end
    end

    // Counter bits [4:2] count words down from 7, bits [1:0] bytes down from 3.
    ecc_word_store #(.pDEPTH(pWORDS), .pWORD_W(pWORD_W)) u_rx_store (
        .crypto_clk (crypto_clk),
        .wr_en      (rx_wren_i & wr_accept),
        .wr_addr    (rx_addr_i),
        .wr_data    (rx_din_i),
        .rd_word    (~byte_cnt[4:2]),
        .rd_byte    (~byte_cnt[1:0]),
        .rd_data    (rx_byte)
    );

    ecc_word_store #(.pDEPTH(pWORDS), .pWORD_W(pWORD_W)) u_ry_store (
        .crypto_clk (crypto_clk),
        .wr_en      (ry_wren_i & wr_accept),
        .wr_addr    (ry_addr_i),
        .wr_data    (ry_din_i),
        .rd_word    (~byte_cnt[4:2]),
        .rd_byte    (~byte_cnt[1:0]),
        .rd_data    (ry_byte)
    );

    // Gated by valid so the byte lane reads zero while nothing is offered.
    assign out_data_o       = out_valid_o ? (byte_cnt[5] ? ry_byte : rx_byte) : 8'h00;
    assign out_last_o       = out_valid_o & last_byte;
    assign drain_done_o     = done_q;
    assign err_incomplete_o = inc_q;
    assign err_overrun_o    = ovr_q;
    assign mismatch_o       = mm_q;

endmodule

// File: tb/tb_ecc_pmul_result_drain.sv
// Bench for ecc_pmul_result_drain. Reference model: the result is the
// 512-bit big-endian value rx[7..0] || ry[7..0]; byte k of the stream is
// byte k of that value counted from the most-significant end.
module tb_ecc_pmul_result_drain;

    logic        crypto_clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        core_rdy_i = 1'b0;
    logic [2:0]  rx_addr_i = '0;
    logic        rx_wren_i = 1'b0;
    logic [31:0] rx_din_i = '0;
    logic [2:0]  ry_addr_i = '0;
    logic        ry_wren_i = 1'b0;
    logic [31:0] ry_din_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic        drain_done_o;
    logic        err_incomplete_o;
    logic        err_overrun_o;
    logic        mismatch_o;
`ifdef ECC_PMUL_LOCKSTEP_CMP_EN
    logic        mm_inj = 1'b0;
    logic [31:0] rx_b_din_i;
    logic [31:0] ry_b_din_i;
    assign rx_b_din_i = rx_din_i;
    assign ry_b_din_i = ry_din_i ^ {31'd0, (mm_inj && ry_addr_i == 3'd5)};
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rx_m [8];
    logic [31:0] ry_m [8];
    logic [15:0] written = '0;

    ecc_pmul_result_drain dut (
        .crypto_clk       (crypto_clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .core_rdy_i       (core_rdy_i),
        .rx_addr_i        (rx_addr_i),
        .rx_wren_i        (rx_wren_i),
        .rx_din_i         (rx_din_i),
        .ry_addr_i        (ry_addr_i),
        .ry_wren_i        (ry_wren_i),
        .ry_din_i         (ry_din_i),
`ifdef ECC_PMUL_LOCKSTEP_CMP_EN
        .rx_b_din_i       (rx_b_din_i),
        .ry_b_din_i       (ry_b_din_i),
`endif
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .out_last_o       (out_last_o),
        .drain_done_o     (drain_done_o),
        .err_incomplete_o (err_incomplete_o),
        .err_overrun_o    (err_overrun_o),
        .mismatch_o       (mismatch_o)
    );

    always #5 crypto_clk = ~crypto_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [511:0] flat;
        for (int w = 0; w < 8; w++) begin
            flat[256 + 32*w +: 32] = rx_m[w];
            flat[32*w +: 32]       = ry_m[w];
        end
        return flat[511 - 8*k -: 8];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid_o, 1'b0);
        check({tag, "_data"}, out_data_o, 8'h00);
        check({tag, "_last"}, out_last_o, 1'b0);
        check({tag, "_done"}, drain_done_o, 1'b0);
        check({tag, "_inc"}, err_incomplete_o, 1'b0);
        check({tag, "_ovr"}, err_overrun_o, 1'b0);
        check({tag, "_mm"}, mismatch_o, 1'b0);
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        core_rdy_i = 1'b0;
        tick();
        start_i = 1'b0;
        written = '0;
        check_idle_outputs("start");
    endtask

    // skip: word index to leave unwritten (0..7 rx, 8..15 ry), -1 for none.
    task automatic fill(input bit rnd, input int skip, input bit rdy_with_last);
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = rnd ? $urandom : 32'h1000_0000 + 32'(i);
            b = rnd ? $urandom : 32'h2000_0000 + 32'(i);
            rx_wren_i = (skip != i);
            rx_addr_i = 3'(i);
            rx_din_i  = a;
            ry_wren_i = (skip != 8 + i);
            ry_addr_i = 3'(i);
            ry_din_i  = b;
            if (i == 7 && rdy_with_last) core_rdy_i = 1'b1;
            tick();
            if (skip != i)     begin rx_m[i] = a; written[i] = 1'b1; end
            if (skip != 8 + i) begin ry_m[i] = b; written[8 + i] = 1'b1; end
        end
        rx_wren_i = 1'b0;
        ry_wren_i = 1'b0;
        if (!rdy_with_last) begin
            core_rdy_i = 1'b1;
            tick();
        end
        check("first_valid", out_valid_o, 1'b1);
        check("incomplete", err_incomplete_o, written != 16'hFFFF);
    endtask

    // mode 0: ready high; mode 1: ready alternating with a 5-cycle stall at byte 17.
    task automatic drain(input int mode, input int ovr_at, input int abort_at,
                         input int rst_at, input int dc_lo, input int dc_hi);
        int idx, cyc, hold;
        bit done, acc, ovr_pend, ovr_done;
        logic [31:0] a;
        idx = 0; cyc = 0; hold = 0;
        done = 0; ovr_pend = 0; ovr_done = 0;
        while (!done && cyc < 400) begin
            if (mode == 1 && idx == 17 && hold < 5) begin
                out_ready_i = 1'b0;
                hold++;
            end else if (mode == 1) begin
                out_ready_i = (cyc % 2 == 0);
            end else begin
                out_ready_i = 1'b1;
            end
            check("drain_valid", out_valid_o, 1'b1);
            if (idx < dc_lo || idx > dc_hi) check($sformatf("byte%0d", idx), out_data_o, exp_byte(idx));
            check("last", out_last_o, idx == 63);
            if (idx == abort_at) begin
                a = $urandom;
                start_i = 1'b1;
                core_rdy_i = 1'b0;
                rx_wren_i = 1'b1;
                rx_addr_i = 3'd0;
                rx_din_i = a;
                tick();
                start_i = 1'b0;
                rx_wren_i = 1'b0;
                rx_m[0] = a;
                written = 16'h0001;
                check_idle_outputs("abort");
                return;
            end
            if (idx == rst_at) begin
                reset_i = 1'b1;
                tick();
                reset_i = 1'b0;
                check_idle_outputs("mid_reset");
                return;
            end
            if (idx == ovr_at && !ovr_done) begin
                rx_wren_i = 1'b1;
                rx_addr_i = 3'd2;
                rx_din_i = ~rx_m[2];
                ovr_pend = 1;
            end
            acc = out_ready_i;
            tick();
            rx_wren_i = 1'b0;
            if (ovr_pend) begin
                check("overrun", err_overrun_o, 1'b1);
                ovr_pend = 0;
                ovr_done = 1;
            end
            if (acc) begin
                idx++;
                if (idx == 64) begin
                    check("end_valid", out_valid_o, 1'b0);
                    check("end_done", drain_done_o, 1'b1);
                    tick();
                    check("done_pulse", drain_done_o, 1'b0);
                    done = 1;
                end
            end
            cyc++;
        end
        out_ready_i = 1'b0;
        check("drain_timeout", done, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        reset_i = 1'b0;
        check_idle_outputs("reset");

        // Directed fill; the last words arrive on the same cycle core_rdy_i rises.
        start_pulse();
        fill(1'b0, -1, 1'b1);
        check("byte0_const", out_data_o, 8'h10);
        drain(0, -1, -1, -1, 99, 99);
        check("dir_inc", err_incomplete_o, 1'b0);
        check("dir_ovr", err_overrun_o, 1'b0);

        // Random data under backpressure.
        start_pulse();
        fill(1'b1, -1, 1'b0);
        drain(1, -1, -1, -1, 99, 99);

        // Missing ry word 3, overrun write during drain, restart at byte 40.
        start_pulse();
        fill(1'b1, 11, 1'b0);
        drain(0, 10, 40, -1, 48, 51);
        // rx word 0 was supplied by the write on the restart cycle.
        fill(1'b1, 0, 1'b0);
        drain(0, -1, -1, -1, 99, 99);

        // Reset mid-drain, then writes and a core_rdy_i rise while idle.
        start_pulse();
        fill(1'b1, -1, 1'b0);
        drain(0, -1, -1, 20, 99, 99);
        core_rdy_i = 1'b0;
        tick();
        rx_wren_i = 1'b1;
        ry_wren_i = 1'b1;
        core_rdy_i = 1'b1;
        tick();
        rx_wren_i = 1'b0;
        ry_wren_i = 1'b0;
        tick();
        check_idle_outputs("idle_writes");

`ifdef ECC_PMUL_LOCKSTEP_CMP_EN
        start_pulse();
        mm_inj = 1'b1;
        fill(1'b1, -1, 1'b0);
        mm_inj = 1'b0;
        check("mismatch_set", mismatch_o, 1'b1);
        drain(0, -1, -1, -1, 99, 99);
        check("mismatch_sticky", mismatch_o, 1'b1);
        start_pulse();
`else
        start_pulse();
        fill(1'b1, -1, 1'b0);
        check("mismatch_tied", mismatch_o, 1'b0);
        drain(0, -1, -1, -1, 99, 99);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
